palette_lut: RTL and testbench
==============================

# palette_lut

Runtime-programmable, double-buffered colour palette for the VGA pixel path. Maps a per-pixel index to a `{red, green, blue}` triple through a 2-stage registered lookup. The CPU/loader writes a shadow bank while the display reads the active bank. Banks swap only at a frame boundary, so palette updates never tear mid-frame.

## Interface
- `INDEX_W`, default 4: index width; each bank holds 2**INDEX_W entries.
- `CH_W`, default 4: width of each colour channel.
- `Clk` input, 1 bit: pixel clock; all state updates on its rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `pix_valid_i` input, 1 bit: `index_i` carries a pixel this cycle.
- `index_i` input, INDEX_W bits: palette index to look up.
- `frame_start_i` input, 1 bit: one-cycle pulse at the start of each frame (vsync).
- `wr_en_i` input, 1 bit: write one shadow-bank entry.
- `wr_addr_i` input, INDEX_W bits: shadow entry address.
- `wr_data_i` input, 3*CH_W bits: `{r, g, b}`, with r in the MSBs.
- `swap_req_i` input, 1 bit: request a bank swap at the next frame start.
- `swap_pending_o` output, 1 bit: a swap is armed but not yet taken.
- `active_bank_o` output, 1 bit: bank currently being displayed.
- `pix_valid_o` output, 1 bit: `red`/`green`/`blue` are valid.
- `red`, `green`, `blue` outputs, CH_W bits each: looked-up colour.

## Operation
- Storage is two banks, 0 and 1, each with 2**INDEX_W entries of 3*CH_W bits.
  - Reads use bank `active_bank_o`.
  - Writes use bank `~active_bank_o`, as sampled in the write cycle.
- Reset defaults, loaded into both banks:
  - Entry i = `{c, c, c}` with c = i mod 2**CH_W.
  - For the default parameters this gives a 16-level grey ramp.
- Swap control has two states:
  - **IDLE**: `swap_req_i` moves the block to ARMED.
  - **ARMED**: `frame_start_i` toggles `active_bank_o` and returns the block to IDLE.
  - `swap_req_i` while ARMED stays ARMED; requests do not accumulate.
  - `swap_req_i` and `frame_start_i` in the same IDLE cycle: the swap happens in that cycle.
  - `frame_start_i` in IDLE has no effect.
- `swap_pending_o` is 1 exactly while the block is in ARMED.
- Write in the same cycle as a swap: the write targets the pre-swap shadow bank, which becomes active after the edge.
- Writes are accepted at any time; no write port is ever stalled.
- Lookup pipeline:
  - Stage 1 registers `index_i`, `pix_valid_i` and the active-bank select.
  - Stage 2 registers the RAM read data and the valid bit.
  - A pixel accepted before a swap edge completes from the old bank, even if it is still in flight.
- When `pix_valid_o` is 0, the colour outputs hold their previous value.

## Timing
- Latency is exactly 2 cycles: pixel in at cycle N gives `pix_valid_o` and colour at cycle N+2.
- Throughput is 1 pixel per cycle with no bubbles.
- A write at cycle N is visible to a lookup from that bank issued at cycle N+1 or later.
- `active_bank_o` changes at the edge where the swap is taken.
- Reset values of outputs:
  - `pix_valid_o`=0, `red`/`green`/`blue`=0, `active_bank_o`=0, `swap_pending_o`=0.
  - Pipeline registers are cleared; the banks are reloaded with the defaults.
- Reset asserted while ARMED drops the pending swap, and all in-flight pixels are discarded.

## Configuration
- `PALETTE_TRANSPARENT_EN` defined:
  - Adds parameter `TRANSP_INDEX` (default 0) and a 1-bit output `transparent_o`.
  - `transparent_o` is 1 when the pixel's index equals `TRANSP_INDEX`.
  - It is aligned with `pix_valid_o` and reset to 0.
  - The colour outputs still present the palette entry, so the downstream mux decides.
- Undefined: no `TRANSP_INDEX` parameter, no `transparent_o` port, and all other behaviour is identical.

## Test plan
- Reset defaults: release reset, then stream indices 0..15 back-to-back. Expect `{i,i,i}` for each, 2 cycles after input, with `pix_valid_o` continuously high for 16 cycles.
- Shadow isolation: write addr 3 = 12'hF00, then look up index 3.
  - Without a swap: expect `{3,3,3}`.
  - After `swap_req_i` and a `frame_start_i` pulse: `active_bank_o`=1 and index 3 gives `{F,0,0}`.
- Armed hold: pulse `swap_req_i`, wait 100 cycles. `swap_pending_o` stays 1 and the bank is unchanged; the next `frame_start_i` swaps and clears pending. A second `frame_start_i` does nothing.
- Simultaneous events: `swap_req_i`, `frame_start_i` and a write to addr 5 = 12'h0A0 in the same cycle. Expect `active_bank_o` toggled and `swap_pending_o`=0; index 5 now reads `{0,A,0}`.
- In-flight across swap: issue index 7 in cycle N and swap at edge N+1. The output at N+2 comes from the old bank.
- Reset mid-operation: assert `Reset` while ARMED with pixels in flight.
  - Expect all outputs 0 immediately (asynchronous) and no `pix_valid_o` after release.
  - Index 3 reads `{3,3,3}` again.
  - With `PALETTE_TRANSPARENT_EN` and `TRANSP_INDEX`=0: index 0 gives `transparent_o`=1 and index 1 gives 0.

Source files
------------

// File: rtl/palette_lut.sv
// Double-buffered colour palette with a 2-stage registered lookup; the bank swap waits for frame start.
// Optional PALETTE_TRANSPARENT_EN adds TRANSP_INDEX and a pixel-aligned transparent_o flag.
//
// state | meaning
// IDLE  | no swap requested; active bank is stable
// ARMED | swap requested; taken at the next frame_start_i
module palette_lut #(
  parameter int INDEX_W = 4,
  parameter int CH_W    = 4
`ifdef PALETTE_TRANSPARENT_EN
  , parameter int TRANSP_INDEX = 0
`endif
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                pix_valid_i,
  input  logic [INDEX_W-1:0]  index_i,
  input  logic                frame_start_i,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_addr_i,
  input  logic [3*CH_W-1:0]   wr_data_i,
  input  logic                swap_req_i,
  output logic                swap_pending_o,
  output logic                active_bank_o,
  output logic                pix_valid_o,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue
`ifdef PALETTE_TRANSPARENT_EN
  , output logic              transparent_o
`endif
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int PIX_W = 3 * CH_W;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} swap_state_e;

  swap_state_e        state_q, state_d;
  logic               active_bank_q, active_bank_d;
  logic               swap_take;

  logic [PIX_W-1:0]   bank_q [2][DEPTH];

  logic [INDEX_W-1:0] idx1_q;
  logic               vld1_q;
  logic               bank1_q;
  logic [PIX_W-1:0]   rd_data;
  logic [PIX_W-1:0]   rgb_q;
  logic               vld2_q;

  function automatic logic [PIX_W-1:0] grey_entry(input int i);
    logic [CH_W-1:0] c;
    c = CH_W'(i);
    return {c, c, c};
  endfunction

  // A request arriving together with frame start is taken immediately.
  assign swap_take = frame_start_i && ((state_q == ARMED) || swap_req_i);

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    if (swap_take) begin
      state_d       = IDLE;
      active_bank_d = ~active_bank_q;
    end else if (swap_req_i) begin
      state_d = ARMED;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      active_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
    end
  end

  // Writes always land in the bank that is shadow during the write cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_q[b][i] <= grey_entry(i);
        end
      end
    end else if (wr_en_i) begin
      bank_q[~active_bank_q][wr_addr_i] <= wr_data_i;
    end
  end

  // Bank select travels with the pixel so in-flight lookups ignore a swap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx1_q  <= '0;
      vld1_q  <= 1'b0;
      bank1_q <= 1'b0;
    end else begin
      idx1_q  <= index_i;
      vld1_q  <= pix_valid_i;
      bank1_q <= active_bank_q;
    end
  end

  assign rd_data = bank_q[bank1_q][idx1_q];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        rgb_q <= rd_data;
      end
    end
  end

`ifdef PALETTE_TRANSPARENT_EN
  logic transp_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      transp_q <= 1'b0;
    end else begin
      transp_q <= vld1_q && (idx1_q == INDEX_W'(TRANSP_INDEX));
    end
  end

  assign transparent_o = transp_q;
`else
  // No transparency flag in this build.
`endif

  assign swap_pending_o = (state_q == ARMED);
  assign active_bank_o  = active_bank_q;
  assign pix_valid_o    = vld2_q;
  assign red            = rgb_q[3*CH_W-1:2*CH_W];
  assign green          = rgb_q[2*CH_W-1:CH_W];
  assign blue           = rgb_q[CH_W-1:0];

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: a bank/swap reference model predicts each pixel, a monitor checks arrival.
module tb_palette_lut;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid_i;
  logic [3:0]  index_i;
  logic        frame_start_i;
  logic        wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [11:0] wr_data_i;
  logic        swap_req_i;
  logic        swap_pending_o;
  logic        active_bank_o;
  logic        pix_valid_o;
  logic [3:0]  red, green, blue;
`ifdef PALETTE_TRANSPARENT_EN
  logic        transparent_o;
`endif

  palette_lut dut (
    .Clk            (clk),
    .Reset          (rst),
    .pix_valid_i    (pix_valid_i),
    .index_i        (index_i),
    .frame_start_i  (frame_start_i),
    .wr_en_i        (wr_en_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .swap_req_i     (swap_req_i),
    .swap_pending_o (swap_pending_o),
    .active_bank_o  (active_bank_o),
    .pix_valid_o    (pix_valid_o),
    .red            (red),
    .green          (green),
    .blue           (blue)
`ifdef PALETTE_TRANSPARENT_EN
    , .transparent_o (transparent_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [11:0] last_rgb = '0;

  // Reference model: two banks of 16 colours, the displayed bank, and a pending flag.
  logic [11:0] m_bank [2][16];
  logic        m_active;
  logic        m_armed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++)
        m_bank[b][i] = {i[3:0], i[3:0], i[3:0]};
    m_active = 1'b0;
    m_armed  = 1'b0;
  endtask

  // One clock cycle of stimulus; model updated as the spec describes, then control outputs checked.
  task automatic cycle(input logic pv, input logic [3:0] idx, input logic fs,
                       input logic we, input logic [3:0] wa, input logic [11:0] wd,
                       input logic sr);
    exp_t e;
    pix_valid_i   = pv;
    index_i       = idx;
    frame_start_i = fs;
    wr_en_i       = we;
    wr_addr_i     = wa;
    wr_data_i     = wd;
    swap_req_i    = sr;
    if (pv) begin
      e.due = cyc + 2;
      e.rgb = m_bank[m_active][idx];
      e.tr  = (idx == 4'd0);
      sb.push_back(e);
    end
    if (we) m_bank[!m_active][wa] = wd;
    if (fs && (m_armed || sr)) begin
      m_active = !m_active;
      m_armed  = 1'b0;
    end else if (sr) begin
      m_armed = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("active_bank", {31'd0, active_bank_o}, {31'd0, m_active});
    chk("swap_pending", {31'd0, swap_pending_o}, {31'd0, m_armed});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0);
  endtask

  task automatic pix(input logic [3:0] idx);
    cycle(1'b1, idx, 1'b0, 1'b0, 4'd0, 12'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_valid"}, {31'd0, pix_valid_o}, 32'd0);
    chk({tag, "_rgb"}, {20'd0, red, green, blue}, 32'd0);
    chk({tag, "_active_bank"}, {31'd0, active_bank_o}, 32'd0);
    chk({tag, "_swap_pending"}, {31'd0, swap_pending_o}, 32'd0);
`ifdef PALETTE_TRANSPARENT_EN
    chk({tag, "_transparent"}, {31'd0, transparent_o}, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pixel due=%0d now=%0d expected_rgb=%03h", sb[0].due, cyc, sb[0].rgb);
        void'(sb.pop_front());
      end
      if (pix_valid_o) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel actual_rgb=%03h expected=none (cycle %0d)", {red, green, blue}, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", cyc, mon_e.due);
          chk("rgb", {20'd0, red, green, blue}, {20'd0, mon_e.rgb});
`ifdef PALETTE_TRANSPARENT_EN
          chk("transparent", {31'd0, transparent_o}, {31'd0, mon_e.tr});
`endif
          last_rgb = mon_e.rgb;
        end
      end else begin
        chk("rgb_hold", {20'd0, red, green, blue}, {20'd0, last_rgb});
      end
    end
  end

  initial begin
    logic       r_pv, r_fs, r_we, r_sr;
    logic [3:0] r_idx, r_wa;
    logic [11:0] r_wd;

    rst = 1'b1;
    pix_valid_i = 0; index_i = 0; frame_start_i = 0; wr_en_i = 0;
    wr_addr_i = 0; wr_data_i = 0; swap_req_i = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Reset grey ramp, back-to-back
    for (int i = 0; i < 16; i++) pix(4'(i));
    idle(3);

    // Shadow isolation
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 12'hF00, 1'b0);
    pix(4'd3);
    idle(2);
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 12'd0, 1'b0);
    chk("bank_after_first_swap", {31'd0, active_bank_o}, 32'd1);
    pix(4'd3);
    idle(3);

    // Armed hold across 100 cycles with pixels flowing
    cycle(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 12'd0, 1'b1);
    for (int k = 0; k < 100; k++) pix(4'(k));
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 12'd0, 1'b0);
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 12'd0, 1'b0);
    idle(2);

    // Request, frame start and write in the same cycle
    cycle(1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 12'h0A0, 1'b1);
    pix(4'd5);
    idle(3);

    // In-flight pixel across a swap edge
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 12'h123, 1'b1);
    pix(4'd7);
    cycle(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 12'd0, 1'b0);
    pix(4'd7);
    idle(3);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      r_pv  = ($urandom_range(0, 3) != 0);
      r_idx = 4'($urandom_range(0, 15));
      r_fs  = ($urandom_range(0, 19) == 0);
      r_we  = ($urandom_range(0, 1) == 0);
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = 12'($urandom_range(0, 4095));
      r_sr  = ($urandom_range(0, 15) == 0);
      cycle(r_pv, r_idx, r_fs, r_we, r_wa, r_wd, r_sr);
    end
    idle(3);

    // Reset while armed, bank 1 active, pixels in flight
    if (!m_active) begin
      cycle(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 12'd0, 1'b1);
    end
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 12'hABC, 1'b1);
    pix(4'd3);
    pix(4'd9);
    #3;
    rst = 1'b1;
    pix_valid_i = 0; frame_start_i = 0; wr_en_i = 0; swap_req_i = 0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    last_rgb = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);
    pix(4'd3);
    pix(4'd0);
    pix(4'd1);
    idle(4);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
